// File: rtl/oam_dma_engine.sv
// rtl/oam_dma_engine.sv - OAM DMA bus initiator: copies LENGTH bytes from a source page to OAM.
// Outputs are registered from the next-state decode, so nothing on cpu_* reaches an output combinationally.
module oam_dma_engine #(
  parameter int          LENGTH      = 160,
  parameter logic [15:0] DEST_BASE   = 16'hFE00,
  parameter logic [15:0] TRIG_ADDR   = 16'hFF46,
  parameter int          START_DELAY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_wdata,
  input  logic [7:0]  bus_rdata,
  output logic [15:0] dma_addr,
  output logic        dma_oe,
  output logic        dma_we,
  output logic [7:0]  dma_wdata,
  output logic        dma_active,
  output logic        dma_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_READ,
    S_WRITE
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(LENGTH - 1);
  localparam logic [7:0] DLY_LAST = 8'(START_DELAY - 1);

  state_t      r_state;
  logic [7:0]  r_idx;
  logic [7:0]  r_page;
  logic [7:0]  r_dly;
  logic [7:0]  r_latch;

  state_t      w_state;
  logic [7:0]  w_idx;
  logic [7:0]  w_page;
  logic [7:0]  w_dly;
  logic [7:0]  w_latch;
  logic [7:0]  w_eff_page;
  logic [15:0] w_addr;
  logic        w_trig;
  logic        w_done;

  assign w_trig = cpu_we && (cpu_addr == TRIG_ADDR);

  always_comb begin
    w_state = r_state;
    w_idx   = r_idx;
    w_page  = r_page;
    w_dly   = r_dly;
    w_latch = r_latch;
    w_done  = 1'b0;
    if (r_state == S_READ) w_latch = bus_rdata;
    // A trigger overrides whatever the FSM would otherwise do, including the final write.
    if (w_trig) begin
      w_state = S_START;
      w_idx   = 8'd0;
      w_page  = cpu_wdata;
      w_dly   = 8'd0;
    end else begin
      case (r_state)
        S_START: begin
          if (r_dly == DLY_LAST) w_state = S_READ;
          else                   w_dly   = r_dly + 8'd1;
        end
        S_READ:  w_state = S_WRITE;
        S_WRITE: begin
          if (r_idx == LAST_IDX) begin
            w_state = S_IDLE;
            w_done  = 1'b1;
          end else begin
            w_idx   = r_idx + 8'd1;
            w_state = S_READ;
          end
        end
        default: w_state = S_IDLE;
      endcase
    end
  end

  // Echo RAM pages E0..FF alias C0..DF.
  assign w_eff_page = (w_page >= 8'hE0) ? (w_page & 8'hDF) : w_page;

  always_comb begin
    w_addr = 16'h0000;
    case (w_state)
      S_READ:  w_addr = {w_eff_page, w_idx};
      S_WRITE: w_addr = DEST_BASE + {8'h00, w_idx};
      default: w_addr = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_idx      <= 8'd0;
      r_page     <= 8'd0;
      r_dly      <= 8'd0;
      r_latch    <= 8'd0;
      dma_addr   <= 16'h0000;
      dma_oe     <= 1'b0;
      dma_we     <= 1'b0;
      dma_wdata  <= 8'd0;
      dma_active <= 1'b0;
      dma_done   <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_idx      <= w_idx;
      r_page     <= w_page;
      r_dly      <= w_dly;
      r_latch    <= w_latch;
      dma_addr   <= w_addr;
      dma_oe     <= (w_state == S_READ);
      dma_we     <= (w_state == S_WRITE);
      dma_wdata  <= (w_state == S_WRITE) ? w_latch : 8'd0;
      dma_active <= (w_state != S_IDLE);
      dma_done   <= w_done;
    end
  end

endmodule

// File: doc/oam_dma_engine.md
Name: oam_dma_engine

Overview:
- Bus initiator that performs the OAM DMA copy triggered by a CPU write to 0xFF46.
- Copies LENGTH bytes from source page (page<<8) to DEST_BASE, one byte read then one byte written per index.
- Drives a dedicated address/OE/WE/data port. Top level muxes this port onto the memory-unit bus while dma_active is high, and holds the CPU off the bus during that time.

Parameters:
- LENGTH, 160: bytes per transfer (1..255).
- DEST_BASE, 16'hFE00: first destination address (OAM).
- TRIG_ADDR, 16'hFF46: CPU write address that starts a transfer.
- START_DELAY, 1: idle cycles between trigger and first read (>=1).

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  asynchronous reset, active low.
- cpu_addr  in  16  CPU bus address.
- cpu_we  in  1  CPU write strobe.
- cpu_wdata  in  8  CPU write data (source page on trigger).
- bus_rdata  in  8  memory-unit read data, combinational from dma_addr.
- dma_addr  out  16  DMA bus address.
- dma_oe  out  1  DMA read enable.
- dma_we  out  1  DMA write enable; memory captures at next posedge.
- dma_wdata  out  8  DMA write data.
- dma_active  out  1  high while the engine owns the bus.
- dma_done  out  1  one-cycle pulse when a transfer completes.

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE, idx=0, page=0, delay count=0, data latch=0.
  - All outputs 0.
- Trigger: any posedge with cpu_we=1 and cpu_addr==TRIG_ADDR.
  - page<=cpu_wdata, idx<=0, delay count<=0, state<=START.
  - Applies in every state, including mid-transfer (restart from index 0 with the new page; no dma_done for the aborted transfer).
  - A trigger held for multiple cycles re-arms each cycle, which is harmless.
  - A trigger in the same cycle as the final WRITE wins: the transfer restarts and dma_done is not pulsed.
- Echo mapping: if page>=8'hE0, effective page = page & 8'hDF (E0->C0, FE->DE). Otherwise the page is used verbatim.
- States:
  - IDLE: outputs 0.
  - START: dma_active=1, oe=we=0, addr=0. Stays START_DELAY cycles, then goes to READ.
  - READ: dma_addr={eff_page, idx}, dma_oe=1, dma_we=0. At posedge, latch bus_rdata and go to WRITE.
  - WRITE: dma_addr=DEST_BASE+idx, dma_we=1, dma_oe=0, dma_wdata=latch.
    - If idx==LENGTH-1: go to IDLE and pulse dma_done in the following cycle.
    - Otherwise: idx<=idx+1 and go to READ.
- dma_active=1 in START/READ/WRITE, 0 in IDLE.
- Latency: trigger sampled at edge N gives the first READ cycle starting at edge N+START_DELAY. dma_active lasts START_DELAY+2*LENGTH cycles (321 at defaults).
- dma_done is high for exactly the one cycle after the final WRITE cycle. dma_active is 0 in that cycle.
- oe and we are never both 1.
- dma_wdata is 0 outside WRITE.
- Outputs are decoded from registered state only. There is no combinational path from cpu_* to any output.
- idx is 8 bits and never exceeds LENGTH-1. Destination arithmetic is 16-bit with no carry beyond DEST_BASE+LENGTH-1.
- Reset asserted mid-transfer: immediate return to IDLE, outputs 0, no dma_done. Partially written OAM is left as is.

Test Plan:
- Basic copy:
  - Stimulus: C000..C09F preloaded with i^8'h5A; write 8'hC0 to FF46.
  - Response: 160 writes FE00..FE9F with matching data; dma_active high exactly 321 cycles; dma_done one pulse; oe/we never overlap.
- Echo page:
  - Stimulus: write 8'hE1 to FF46.
  - Response: reads address C100..C19F; OAM gets the C1xx contents.
- Restart:
  - Stimulus: start page C0; at the READ for idx=50, write 8'hC2 to FF46.
  - Response: idx resets to 0; OAM ends with C200..C29F data; single dma_done, 321 cycles after the second trigger.
- Non-trigger writes:
  - Stimulus: cpu_we to FF45, FF47, 7F46.
  - Response: state stays IDLE; dma_active 0; all outputs 0.
- Reset mid-operation:
  - Stimulus: rst_n low at idx=80 WRITE.
  - Response: outputs 0 in the same cycle (async); no dma_done; idle after rst_n release until the next trigger.
- Trigger on last WRITE:
  - Stimulus: page 8'h00 (ROM 0000..009F); write to FF46 coincident with the final WRITE.
  - Response: no dma_done; new transfer starts from idx 0.
